// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous program/data memory between the processor and a
//   host (loader/debug) port. The processor cannot be stalled mid-instruction,
//   so the host is admitted only at instruction boundaries. The arbiter gates
//   Run, waits for Done, and holds the memory with the processor for SETTLE
//   more cycles so its registered write can land. Host bursts are capped at
//   MAX_BURST accesses. The processor then gets QUANTUM instructions before
//   the next grant, unless it is idle (run_in=0).
//
// Ports
//   Clock, Resetn        clock, asynchronous active-low reset
//   run_in / proc_run    external Run request / Run to the processor
//   proc_done            processor Done
//   proc_addr/dout/w     processor memory request
//   proc_din             memory read data to the processor
//   host_req/we/addr/wdata  host request (level), write flag, address, data
//   host_gnt             host owns the memory this cycle
//   host_ack             access accepted last cycle has completed
//   host_rdata           read data, meaningful with host_ack
//   mem_addr/wdata/we    memory request
//   mem_rdata            memory read data (one-cycle latency)
//   state_q              current arbiter state (debug)
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8,
  parameter int QUANTUM   = 4,
  parameter int SETTLE    = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          run_in,
  output logic          proc_run,
  input  logic          proc_done,
  input  logic [AW-1:0] proc_addr,
  input  logic [DW-1:0] proc_dout,
  input  logic          proc_w,
  output logic [DW-1:0] proc_din,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state_q
);

  typedef enum logic [1:0] {
    ST_PROC   = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_HOST   = 2'b11
  } state_t;

  localparam logic [7:0] LP_BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] LP_QUANT      = 8'(QUANTUM);
  localparam logic [1:0] LP_SETTLE     = 2'(SETTLE);

  state_t     r_state;
  logic [7:0] r_burst_cnt;
  logic [7:0] r_quantum_cnt;
  logic [1:0] r_settle_cnt;
  logic       r_host_ack;

  state_t     w_state_nxt;
  logic [7:0] w_burst_nxt;
  logic [7:0] w_quantum_nxt;
  logic [1:0] w_settle_nxt;
  logic       w_accept;
  logic       w_host_sel;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state       <= ST_PROC;
      r_burst_cnt   <= 8'd0;
      r_quantum_cnt <= LP_QUANT;   // host is eligible straight out of reset
      r_settle_cnt  <= 2'd0;
      r_host_ack    <= 1'b0;       // an in-flight host access is dropped
    end else begin
      r_state       <= w_state_nxt;
      r_burst_cnt   <= w_burst_nxt;
      r_quantum_cnt <= w_quantum_nxt;
      r_settle_cnt  <= w_settle_nxt;
      r_host_ack    <= w_accept;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_burst_nxt   = r_burst_cnt;
    w_quantum_nxt = r_quantum_cnt;
    w_settle_nxt  = r_settle_cnt;
    w_accept      = 1'b0;
    case (r_state)
      ST_PROC: begin
        if (proc_done && (r_quantum_cnt < LP_QUANT))
          w_quantum_nxt = r_quantum_cnt + 8'd1;
        // An idle processor (run_in=0) owes no quantum.
        if (host_req && ((r_quantum_cnt >= LP_QUANT) || !run_in))
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A withdrawn request wins over a coincident Done: nothing to grant.
        if (!host_req) begin
          w_state_nxt = ST_PROC;
        end else if (proc_done) begin
          w_settle_nxt = LP_SETTLE;
          w_state_nxt  = (SETTLE == 0) ? ST_HOST : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_settle_nxt = r_settle_cnt - 2'd1;
        if (r_settle_cnt <= 2'd1)
          w_state_nxt = ST_HOST;
      end
      ST_HOST: begin
        if (!host_req) begin
          w_state_nxt   = ST_PROC;
          w_burst_nxt   = 8'd0;
          w_quantum_nxt = 8'd0;
        end else begin
          w_accept = 1'b1;
          if (r_burst_cnt >= LP_BURST_LAST) begin
            // Burst limit: the last access still acks in the first PROC cycle.
            w_state_nxt   = ST_PROC;
            w_burst_nxt   = 8'd0;
            w_quantum_nxt = 8'd0;
          end else begin
            w_burst_nxt = r_burst_cnt + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_PROC;
    endcase
  end

  assign w_host_sel = (r_state == ST_HOST);

  // Run is combinationally forced low during reset, not just after it.
  assign proc_run   = Resetn && run_in && (r_state == ST_PROC);
  assign host_gnt   = w_host_sel;
  assign host_ack   = r_host_ack;
  assign host_rdata = mem_rdata;
  assign proc_din   = mem_rdata;

  // Single mux: only one source can ever drive mem_we.
  assign mem_addr   = w_host_sel ? host_addr  : proc_addr;
  assign mem_wdata  = w_host_sel ? host_wdata : proc_dout;
  assign mem_we     = w_host_sel ? (host_req && host_we) : proc_w;

  assign state_q    = r_state;

endmodule
